// File: rtl/rv32i_control_pkg.sv
// Shared control-path types for the rv32i core: memory-port ownership,
// arbiter FSM states and the memory request record.
package rv32i_control_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        OWNER_NONE,
        OWNER_IF,
        OWNER_DATA
    } mem_owner_e;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_RESP
    } arb_state_e;

    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [XLEN/8-1:0] be;
    } mem_req_t;

endpackage

// File: rtl/rv32i_mem_arb_select.sv
// Winner selection for the unified memory port: data first, unless fetch
// has been passed over STARVE_LIMIT times in a row.
module rv32i_mem_arb_select
    import rv32i_control_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                    if_req_i,
    input  logic                    d_req_i,
    input  logic [STARVE_CNT_W-1:0] starve_cnt_i,
    output mem_owner_e              winner_o
);

    logic fetch_starved;

    assign fetch_starved = (starve_cnt_i == STARVE_CNT_W'(STARVE_LIMIT));

    always_comb begin
        winner_o = OWNER_NONE;
        if (if_req_i && (!d_req_i || fetch_starved)) begin
            winner_o = OWNER_IF;
        end else if (d_req_i) begin
            winner_o = OWNER_DATA;
        end
    end

endmodule

// File: rtl/rv32i_mem_port_arbiter.sv
// Single-ported memory arbiter between instruction fetch and load/store,
// one outstanding req/gnt/rvalid transaction, with structural-hazard output.
module rv32i_mem_port_arbiter
    import rv32i_control_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    output logic                    if_accept_o,
    output logic                    if_rvalid_o,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,
    input  logic                    d_req_i,
    input  logic                    d_we_i,
    input  logic [ADDR_WIDTH-1:0]   d_addr_i,
    input  logic [DATA_WIDTH-1:0]   d_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] d_be_i,
    output logic                    d_accept_o,
    output logic                    d_rvalid_o,
    output logic [DATA_WIDTH-1:0]   d_rdata_o,
    input  logic                    flush_i,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    structural_hazard_o
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_WIDTH-1:0]   be;
    } port_req_t;

    arb_state_e              state_q, state_d;
    mem_owner_e              owner_q, owner_d, winner, cur_owner;
    port_req_t               req_q, req_d, win_req, cur_req;
    logic [STARVE_CNT_W-1:0] starve_q, starve_d;
    logic                    discard_q, discard_d;
    logic                    active, granted, resp_fire;

    rv32i_mem_arb_select #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_select (
        .if_req_i    (if_req_i),
        .d_req_i     (d_req_i),
        .starve_cnt_i(starve_q),
        .winner_o    (winner)
    );

    always_comb begin
        win_req = '0;
        case (winner)
            OWNER_IF: begin
                win_req.addr = if_addr_i;
                win_req.be   = '1;
            end
            OWNER_DATA: begin
                win_req.we    = d_we_i;
                win_req.addr  = d_addr_i;
                win_req.wdata = d_wdata_i;
                win_req.be    = d_be_i;
            end
            default: ;
        endcase
    end

    // IDLE presents the fresh winner straight from its inputs so a grant can
    // land in the arbitration cycle itself; REQ/RESP use the latched copy.
    always_comb begin
        cur_owner = (state_q == ARB_IDLE) ? winner  : owner_q;
        cur_req   = (state_q == ARB_IDLE) ? win_req : req_q;
        active    = rst_ni && (cur_owner != OWNER_NONE) && (state_q != ARB_RESP);
        granted   = active && mem_gnt_i;
        resp_fire = rst_ni && mem_rvalid_i && ((state_q == ARB_RESP) || granted);

        mem_req_o   = active;
        mem_we_o    = active ? cur_req.we    : 1'b0;
        mem_addr_o  = active ? cur_req.addr  : '0;
        mem_wdata_o = active ? cur_req.wdata : '0;
        mem_be_o    = active ? cur_req.be    : '0;

        if_accept_o = granted && (cur_owner == OWNER_IF);
        d_accept_o  = granted && (cur_owner == OWNER_DATA);
        if_rvalid_o = resp_fire && (cur_owner == OWNER_IF) && !discard_q && !flush_i;
        d_rvalid_o  = resp_fire && (cur_owner == OWNER_DATA);
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
        d_rdata_o   = d_rvalid_o  ? mem_rdata_i : '0;

        structural_hazard_o = rst_ni && if_req_i && !if_accept_o;
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        req_d     = req_q;
        starve_d  = starve_q;
        discard_d = discard_q;

        case (state_q)
            ARB_IDLE: begin
                if (winner != OWNER_NONE) begin
                    owner_d = winner;
                    req_d   = win_req;
                    state_d = ARB_REQ;
                    if (granted) state_d = resp_fire ? ARB_IDLE : ARB_RESP;
                end
            end
            ARB_REQ: begin
                if (granted) state_d = resp_fire ? ARB_IDLE : ARB_RESP;
            end
            ARB_RESP: begin
                if (resp_fire) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase

        if (state_d == ARB_IDLE) owner_d = OWNER_NONE;

        if ((state_q != ARB_IDLE) && (owner_q == OWNER_IF) && flush_i) discard_d = 1'b1;
        if (resp_fire) discard_d = 1'b0;

        if (if_accept_o) begin
            starve_d = '0;
        end else if (d_accept_o && if_req_i) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + STARVE_CNT_W'(1);
        end else if ((state_q == ARB_IDLE) && !if_req_i) begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWNER_NONE;
            req_q     <= '0;
            starve_q  <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            req_q     <= req_d;
            starve_q  <= starve_d;
            discard_q <= discard_d;
        end
    end

`ifndef SYNTHESIS
    ap_no_rvalid_before_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == ARB_REQ && mem_rvalid_i) |-> mem_gnt_i);

    ap_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (mem_req_o && !mem_gnt_i) |=> (mem_req_o && $stable(mem_we_o) && $stable(mem_addr_o)
                                       && $stable(mem_wdata_o) && $stable(mem_be_o)));

    ap_rvalid_onehot: assert property (@(posedge clk_i) !(if_rvalid_o && d_rvalid_o));
`endif

endmodule

// File: doc/rv32i_mem_port_arbiter.md
Name: rv32i_mem_port_arbiter

Overview:
Arbitrates the single-ported unified memory between instruction fetch (IF) and load/store (MEM).
It is the producer of the structural_hazard signal consumed by rv32i_hazard_unit, and it asserts that signal whenever a fetch cannot be serviced.
It runs a one-outstanding-transaction req/gnt/rvalid protocol toward memory and routes each response back to its owner.
Data accesses have priority; a starvation counter guarantees forward progress for fetch.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data bus width; byte enables are DATA_WIDTH/8 bits
STARVE_LIMIT, 4, number of consecutive data grants with a fetch waiting before fetch wins one arbitration; range 1..15

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
if_req_i  in  1  fetch request, held until accepted
if_addr_i  in  ADDR_WIDTH  fetch address
if_accept_o  out  1  fetch request accepted this cycle
if_rvalid_o  out  1  fetch data valid, one cycle
if_rdata_o  out  DATA_WIDTH  fetch data
d_req_i  in  1  load/store request, held until accepted
d_we_i  in  1  1 = store
d_addr_i  in  ADDR_WIDTH  data address
d_wdata_i  in  DATA_WIDTH  store data
d_be_i  in  DATA_WIDTH/8  byte enables
d_accept_o  out  1  data request accepted this cycle
d_rvalid_o  out  1  load data valid / store complete, one cycle
d_rdata_o  out  DATA_WIDTH  load data
flush_i  in  1  branch flush; discards the in-flight fetch response
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_WIDTH  memory address
mem_wdata_o  out  DATA_WIDTH  memory write data
mem_be_o  out  DATA_WIDTH/8  memory byte enables
mem_gnt_i  in  1  memory accepts request
mem_rvalid_i  in  1  memory response valid
mem_rdata_i  in  DATA_WIDTH  memory response data
structural_hazard_o  out  1  fetch blocked this cycle

Behaviour:
- Reset (synchronous, rst_ni low at posedge clk_i):
  - state = IDLE, owner = NONE, starve_cnt = 0, discard = 0.
  - All outputs are 0.
- FSM states:
  - IDLE: no transaction. If a request is pending, select a winner and go to REQ in the same cycle (mem_req_o asserted combinationally).
  - REQ: mem_req_o held with stable attributes until mem_gnt_i. Then go to RESP, unless mem_gnt_i and mem_rvalid_i are both high in the same cycle, in which case complete and return to IDLE.
  - RESP: wait for mem_rvalid_i, forward the response, return to IDLE.
- Arbitration (in IDLE only):
  - Data wins over fetch.
  - Exception: fetch wins when starve_cnt == STARVE_LIMIT.
  - The winner's mem_* fields are driven straight from its inputs and latched on mem_gnt_i.
- Accept:
  - if_accept_o / d_accept_o pulse in the cycle mem_gnt_i is high for that owner.
  - The requester drops or changes its request only after accept.
- starve_cnt:
  - Increments on each data grant while if_req_i is high, saturating at STARVE_LIMIT.
  - Clears on a fetch grant, or when if_req_i is low in IDLE.
- Response routing:
  - mem_rvalid_i is routed to if_rvalid_o or d_rvalid_o according to the latched owner; rdata passes through combinationally.
  - Zero added latency: rvalid out in the same cycle as mem_rvalid_i.
- Flush:
  - flush_i while owner = IF in REQ or RESP sets discard.
  - The matching response completes the bus protocol but if_rvalid_o stays 0; discard clears afterward.
  - flush_i never aborts a data transaction.
  - flush_i in the same cycle as mem_rvalid_i for a fetch suppresses that response.
- structural_hazard_o is combinational and equals if_req_i AND NOT (fetch granted this cycle), i.e. fetch blocked by:
  - a data win,
  - a busy bus (REQ/RESP),
  - or an ungranted fetch request.
  It is 0 when if_req_i = 0.
- Simultaneous if_req_i and d_req_i in IDLE with starve_cnt < STARVE_LIMIT: data is granted, structural_hazard_o = 1.
- Reset in REQ or RESP returns to IDLE. A late mem_rvalid_i arriving in IDLE is ignored (no owner).
- Assertions (ENABLE style, simulation only):
  - no mem_rvalid_i in REQ without gnt;
  - mem_* stable while REQ and !mem_gnt_i;
  - if_rvalid_o and d_rvalid_o never both high.

Decomposition:
- rv32i_control_pkg gains:
  - mem_owner_e {OWNER_NONE, OWNER_IF, OWNER_DATA};
  - arb_state_e {ARB_IDLE, ARB_REQ, ARB_RESP};
  - a packed struct mem_req_t {we, addr, wdata, be}.
- Optional sub-module rv32i_mem_arb_select: combinational winner selection from the requests and starve_cnt.
- Target size of the top level: roughly 200 lines.

Test Plan:
- Fetch only: if_req_i = 1, addr 0x100, gnt next cycle, rvalid one cycle later with 0xDEADBEEF -> if_rvalid_o = 1 with that data; structural_hazard_o = 0 on the grant cycle.
- Both requesting in IDLE: d_req_i store to 0x200 plus if_req_i -> mem_we_o = 1, mem_addr_o = 0x200, structural_hazard_o = 1 until the fetch is granted after the store's rvalid.
- Starvation: d_req_i held high with STARVE_LIMIT = 4 -> the 5th arbitration grants fetch; starve_cnt then returns to 0.
- Flush: fetch granted, flush_i pulsed in RESP, rvalid arrives -> if_rvalid_o stays 0, next fetch proceeds normally.
- gnt and rvalid in the same cycle for a load returning 0x12345678 -> d_rvalid_o = 1 that cycle, FSM back in IDLE next cycle.
- Reset asserted in RESP -> all outputs 0 next cycle; a stale mem_rvalid_i produces no rvalid output.
